alu_issue_ctrl: RTL and testbench

Sequential issue stage directly upstream of the combinational `alu`. It accepts operation requests `{a, b, op}` over a valid/ready handshake and buffers them in a small FIFO. It drives one request at a time onto the ALU's `a`/`b`/`c`/`oe` inputs, waits a fixed settle time, then captures `y`/`x` into a result register. The result is presented to the consumer over a second valid/ready handshake.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_op_fifo.sv | 64 ++++++
 rtl/alu_issue_ctrl.sv | 165 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcodes, the request payload and the issue FSM encoding.
package alu_pkg;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned RES_W  = 16;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_INC  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_DIV  = 4'b0101;
    localparam logic [3:0] OP_LAND = 4'b1000;
    localparam logic [3:0] OP_NAND = 4'b1011;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [3:0]        op;
    } alu_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } issue_state_e;

    function automatic logic is_div_zero(input alu_req_t req);
        return (req.op == OP_DIV) && (req.b == '0);
    endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// Synchronous request FIFO; pointers wrap naturally because DEPTH is a power of two.
module alu_op_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  alu_req_t               wdata,
    input  logic                   pop,
    output alu_req_t               rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    alu_req_t          mem_q [DEPTH];
    alu_req_t          mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the combinational ALU: buffers requests, drives one at a time, captures the result.
// Optional macro ALU_DIV_ZERO_CHK_EN short-circuits divide-by-zero requests into an error result.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_a,
    input  logic [3:0]             in_b,
    input  logic [3:0]             in_op,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_c,
    output logic                   alu_oe,
    input  logic [15:0]            alu_y,
    input  logic [15:0]            alu_x,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_y,
    output logic [15:0]            out_x,
    output logic [3:0]             out_op,
    output logic                   out_err,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    issue_state_e      state_q, state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    alu_req_t          opnd_q, opnd_d;
    logic              alu_oe_q, alu_oe_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_y_q, out_y_d;
    logic [15:0]       out_x_q, out_x_d;
    logic [3:0]        out_op_q, out_op_d;
    logic              out_err_q, out_err_d;

    alu_req_t          head;
    alu_req_t          req;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              take_head;

    assign req      = '{a: in_a, b: in_b, op: in_op};
    assign in_ready = !fifo_full;

    alu_op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata (req),
        .pop   (fifo_pop),
        .rdata (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and result-register logic; popping the head is shared by IDLE and HOLD.
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        opnd_d      = opnd_q;
        alu_oe_d    = 1'b0;
        out_valid_d = 1'b0;
        out_y_d     = out_y_q;
        out_x_d     = out_x_q;
        out_op_d    = out_op_q;
        out_err_d   = out_err_q;
        fifo_pop    = 1'b0;
        take_head   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                take_head = !fifo_empty;
            end
            ST_ISSUE: begin
                if (settle_q == '0) begin
                    out_y_d     = alu_y;
                    out_x_d     = alu_x;
                    out_op_d    = opnd_q.op;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                    alu_oe_d = 1'b1;
                end
            end
            ST_HOLD: begin
                out_valid_d = 1'b1;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    take_head   = !fifo_empty;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_head) begin
            fifo_pop = 1'b1;
`ifdef ALU_DIV_ZERO_CHK_EN
            if (is_div_zero(head)) begin
                out_y_d     = '0;
                out_x_d     = '0;
                out_op_d    = OP_DIV;
                out_err_d   = 1'b1;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end else
`endif
            begin
                opnd_d      = head;
                settle_d    = SET_W'(SETTLE - 1);
                alu_oe_d    = 1'b1;
                out_valid_d = 1'b0;
                state_d     = ST_ISSUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            opnd_q      <= '0;
            alu_oe_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_x_q     <= '0;
            out_op_q    <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            opnd_q      <= opnd_d;
            alu_oe_q    <= alu_oe_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_x_q     <= out_x_d;
            out_op_q    <= out_op_d;
            out_err_q   <= out_err_d;
        end
    end

    assign alu_a     = opnd_q.a;
    assign alu_b     = opnd_q.b;
    assign alu_c     = opnd_q.op;
    assign alu_oe    = alu_oe_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_x     = out_x_q;
    assign out_op    = out_op_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU behind two instances (SETTLE=1 and SETTLE=3), queue scoreboard.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] x;
        logic [3:0]  op;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, alu_oe, out_err;
    logic [3:0]  in_a, in_b, in_op, alu_a, alu_b, alu_c, out_op;
    logic [15:0] alu_y, alu_x, out_y, out_x;
    logic [2:0]  count;

    logic        in_valid3, in_ready3, out_valid3, out_ready3, alu_oe3, out_err3;
    logic [3:0]  in_a3, in_b3, in_op3, alu_a3, alu_b3, alu_c3, out_op3;
    logic [15:0] alu_y3, alu_x3, out_y3, out_x3;
    logic [2:0]  count3;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Behavioural ALU; idle outputs are junk so a capture outside ISSUE shows up.
    function automatic logic [31:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c, input logic oe);
        logic [15:0] y;
        logic [15:0] x;
        y = 16'h0;
        x = 16'h0;
        if (!oe) return {16'hDEAD, 16'hBEEF};
        case (c)
            OP_ADD:  y = 16'(a) + 16'(b);
            OP_INC:  y = 16'(a) + 16'd1;
            OP_SUB:  y = 16'(a) - 16'(b);
            OP_MUL:  y = 16'(a) * 16'(b);
            OP_DIV:  if (b != 4'd0) begin y = 16'(a / b); x = 16'(a % b); end
                     else begin y = 16'hFFFF; x = 16'hFFFF; end
            OP_LAND: y = 16'((a != 4'd0) && (b != 4'd0));
            OP_NAND: y = {12'hFFF, ~(a & b)};
            default: y = 16'h0;
        endcase
        return {y, x};
    endfunction

    function automatic exp_t exp_of(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        exp_t        e;
        logic [31:0] r;
        r     = alu_f(a, b, op, 1'b1);
        e.y   = r[31:16];
        e.x   = r[15:0];
        e.op  = op;
        e.err = 1'b0;
`ifdef ALU_DIV_ZERO_CHK_EN
        if (op == OP_DIV && b == 4'd0) begin
            e.y   = 16'h0;
            e.x   = 16'h0;
            e.err = 1'b1;
        end
`endif
        return e;
    endfunction

    assign {alu_y, alu_x}   = alu_f(alu_a, alu_b, alu_c, alu_oe);
    assign {alu_y3, alu_x3} = alu_f(alu_a3, alu_b3, alu_c3, alu_oe3);

    alu_issue_ctrl #(.DEPTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_oe(alu_oe),
        .alu_y(alu_y), .alu_x(alu_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_x(out_x),
        .out_op(out_op), .out_err(out_err), .count(count)
    );

    alu_issue_ctrl #(.DEPTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a3), .in_b(in_b3), .in_op(in_op3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_c(alu_c3), .alu_oe(alu_oe3),
        .alu_y(alu_y3), .alu_x(alu_x3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_y(out_y3), .out_x(out_x3),
        .out_op(out_op3), .out_err(out_err3), .count(count3)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({count, in_ready, alu_oe, out_valid} !== {3'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_ctrl: got count=%0d rdy=%b oe=%b ov=%b want 0 1 0 0", count, in_ready, alu_oe, out_valid);
        else n_pass++;
        n_checks++;
        if ({alu_a, alu_b, alu_c, out_y, out_x, out_op, out_err} !== 49'd0)
            $display("FAIL reset_data: got a=%h b=%h c=%h y=%h x=%h op=%h err=%b want all 0",
                     alu_a, alu_b, alu_c, out_y, out_x, out_op, out_err);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        exp_t e;
        int   lat;
        out_ready = 1'b1;
        in_a = 4'b1000; in_b = 4'b1100; in_op = OP_ADD; in_valid = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", in_ready); else n_pass++;
        sb.push_back(exp_of(in_a, in_b, in_op));
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        n_checks++;
        if (lat != 2) $display("FAIL single_latency: got %0d want 2", lat); else n_pass++;
        n_checks++;
        if ({out_y, out_op} !== {16'h0014, 4'b0000})
            $display("FAIL single_value: got y=%h op=%h want y=0014 op=0", out_y, out_op);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if ({out_y, out_x, out_op, out_err} !== e)
            $display("FAIL single_sb: got %h want %h", {out_y, out_x, out_op, out_err}, e);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL single_drop: got out_valid=%b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [3:0] ops [5] = '{OP_ADD, OP_SUB, OP_NAND, OP_LAND, OP_INC};
        exp_t       first;
        exp_t       e;
        int         n_acc, oe_hi, tries, got, cyc;
        out_ready = 1'b0;
        n_acc = 0; oe_hi = 0; tries = 0;
        while (tries < 10) begin
            if (alu_oe) oe_hi++;
            if (!in_ready) break;
            in_a = 4'(tries + 1); in_b = 4'(tries + 2); in_op = ops[tries % 5]; in_valid = 1'b1;
            sb.push_back(exp_of(in_a, in_b, in_op));
            n_acc++; tries++;
            @(negedge clk);
        end
        n_checks++;
        if ({n_acc, count, in_ready} !== {32'd5, 3'd4, 1'b0})
            $display("FAIL bp_fill: got accepted=%0d count=%0d rdy=%b want 5 4 0", n_acc, count, in_ready);
        else n_pass++;
        first = sb[0];
        repeat (3) begin
            @(negedge clk);
            if (alu_oe) oe_hi++;
            n_checks++;
            if ({count, out_valid, out_y, out_x, out_op} !== {3'd4, 1'b1, first.y, first.x, first.op})
                $display("FAIL bp_hold: got count=%0d ov=%b y=%h op=%h want 4 1 %h %h", count, out_valid, out_y, out_op, first.y, first.op);
            else n_pass++;
        end
        n_checks++;
        if (oe_hi != 1) $display("FAIL bp_oe_pulses: got %0d want 1", oe_hi); else n_pass++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        got = 0; cyc = 0;
        while (got < 5 && cyc < 40) begin
            if (out_valid) begin
                e = sb.pop_front();
                n_checks++;
                if ({out_y, out_x, out_op, out_err} !== e)
                    $display("FAIL bp_order%0d: got %h want %h", got, {out_y, out_x, out_op, out_err}, e);
                else n_pass++;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (got != 5) $display("FAIL bp_count: got %0d results want 5", got); else n_pass++;
    endtask

    task automatic test_mul_stall();
        exp_t e;
        int   cyc;
        out_ready = 1'b0;
        in_a = 4'b0110; in_b = 4'b0110; in_op = OP_MUL; in_valid = 1'b1;
        sb.push_back(exp_of(in_a, in_b, in_op));
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
        repeat (5) begin
            n_checks++;
            if ({out_valid, out_y, alu_oe} !== {1'b1, 16'h0024, 1'b0})
                $display("FAIL mul_stall: got ov=%b y=%h oe=%b want 1 0024 0", out_valid, out_y, alu_oe);
            else n_pass++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        e = sb.pop_front();
        n_checks++;
        if ({out_y, out_x, out_op, out_err} !== e)
            $display("FAIL mul_sb: got %h want %h", {out_y, out_x, out_op, out_err}, e);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL mul_release: got out_valid=%b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_div_zero();
        exp_t e;
        int   cyc, oe_seen;
        out_ready = 1'b0;
        in_a = 4'b1010; in_b = 4'b0000; in_op = OP_DIV; in_valid = 1'b1;
        sb.push_back(exp_of(in_a, in_b, in_op));
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0; oe_seen = 0;
        while (!out_valid && cyc < 20) begin
            if (alu_oe) oe_seen++;
            @(negedge clk);
            cyc++;
        end
`ifdef ALU_DIV_ZERO_CHK_EN
        n_checks++;
        if ({oe_seen, out_err, out_y, out_op, alu_a, alu_b} !== {32'd0, 1'b1, 16'h0, OP_DIV, 4'd6, 4'd6})
            $display("FAIL div0_chk: got oe=%0d err=%b y=%h op=%h a=%h b=%h want 0 1 0000 5 6 6",
                     oe_seen, out_err, out_y, out_op, alu_a, alu_b);
        else n_pass++;
`else
        n_checks++;
        if ({oe_seen, out_err, out_y, out_op} !== {32'd1, 1'b0, 16'hFFFF, OP_DIV})
            $display("FAIL div0_issue: got oe=%0d err=%b y=%h op=%h want 1 0 ffff 5", oe_seen, out_err, out_y, out_op);
        else n_pass++;
`endif
        e = sb.pop_front();
        n_checks++;
        if ({out_valid, out_y, out_x, out_op, out_err} !== {1'b1, e})
            $display("FAIL div0_sb: got ov=%b %h want %h", out_valid, {out_y, out_x, out_op, out_err}, e);
        else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0] as [3] = '{4'd15, 4'd5, 4'd3};
        logic [3:0] bs [3] = '{4'd0, 4'd3, 4'd5};
        logic [3:0] os [3] = '{OP_INC, OP_NAND, OP_SUB};
        int         stamp [3];
        exp_t       e;
        int         t, got;
        out_ready = 1'b1;
        t = 0; got = 0;
        while (got < 3 && t < 40) begin
            if (out_valid) begin
                e = sb.pop_front();
                n_checks++;
                if ({out_y, out_x, out_op, out_err} !== e)
                    $display("FAIL b2b_data%0d: got %h want %h", got, {out_y, out_x, out_op, out_err}, e);
                else n_pass++;
                stamp[got] = t;
                got++;
            end
            if (t < 3) begin
                in_a = as[t]; in_b = bs[t]; in_op = os[t]; in_valid = 1'b1;
                sb.push_back(exp_of(in_a, in_b, in_op));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (got != 3) $display("FAIL b2b_count: got %0d want 3", got);
        else if (stamp[1] - stamp[0] != 2 || stamp[2] - stamp[1] != 2)
            $display("FAIL b2b_spacing: got %0d,%0d want 2,2", stamp[1] - stamp[0], stamp[2] - stamp[1]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc;
        logic seen;
        out_ready = 1'b0;
        in_a = 4'd1; in_b = 4'd1; in_op = OP_ADD; in_valid = 1'b1;
        sb.push_back(exp_of(in_a, in_b, in_op));
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
        for (int i = 0; i < 3; i++) begin
            in_a = 4'(i + 2); in_b = 4'd1; in_op = OP_SUB; in_valid = 1'b1;
            sb.push_back(exp_of(in_a, in_b, in_op));
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, count} !== {1'b1, 3'd3})
            $display("FAIL rstmid_setup: got ov=%b count=%0d want 1 3", out_valid, count);
        else n_pass++;
        out_ready = 1'b1;
        e = sb.pop_front();
        n_checks++;
        if ({out_y, out_x, out_op, out_err} !== e)
            $display("FAIL rstmid_first: got %h want %h", {out_y, out_x, out_op, out_err}, e);
        else n_pass++;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if ({alu_oe, count} !== {1'b1, 3'd2})
            $display("FAIL rstmid_issue: got oe=%b count=%0d want 1 2", alu_oe, count);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({count, out_valid, alu_oe, in_ready} !== {3'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL rstmid_flush: got count=%0d ov=%b oe=%b rdy=%b want 0 0 0 1", count, out_valid, alu_oe, in_ready);
        else n_pass++;
        sb.delete();
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || alu_oe) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL rstmid_quiet: got activity=%b want 0", seen); else n_pass++;
        out_ready = 1'b1;
    endtask

    task automatic test_settle();
        exp_t e;
        int   k, oe_cnt;
        out_ready3 = 1'b1;
        in_a3 = 4'b0011; in_b3 = 4'b0000; in_op3 = OP_INC; in_valid3 = 1'b1;
        sb.push_back(exp_of(in_a3, in_b3, in_op3));
        @(negedge clk);
        in_valid3 = 1'b0;
        k = 0; oe_cnt = 0;
        while (!out_valid3 && k < 20) begin
            if (alu_oe3) oe_cnt++;
            @(negedge clk);
            k++;
        end
        n_checks++;
        if ({oe_cnt, k} !== {32'd3, 32'd4})
            $display("FAIL settle_timing: got oe_cycles=%0d latency=%0d want 3 4", oe_cnt, k);
        else n_pass++;
        n_checks++;
        if ({out_y3, alu_oe3} !== {16'h0004, 1'b0})
            $display("FAIL settle_value: got y=%h oe=%b want 0004 0", out_y3, alu_oe3);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if ({out_y3, out_x3, out_op3, out_err3} !== e)
            $display("FAIL settle_sb: got %h want %h", {out_y3, out_x3, out_op3, out_err3}, e);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
        in_valid3 = 1'b0; in_a3 = '0; in_b3 = '0; in_op3 = '0; out_ready3 = 1'b1;
        test_reset();
        test_single();
        test_backpressure();
        test_mul_stall();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_settle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
